ex_unit: RTL and testbench
==========================

# ex_unit

Parametrised execute stage for the scalar integer pipeline, between the ID/EX and EX/MEM registers. It computes logic, shift and rotate results in one cycle, as the current execute stage does. It adds an iterative signed/unsigned divider that holds the pipeline through a stall request until the quotient and remainder are ready. Operand width and register-address width are generic, so the same block serves the 32-bit core and narrower test configurations.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; power of two, ≥ 8
- `REG_ADDR_W`, 5, destination register address width
- `SHAMT_W`, $clog2(WIDTH), shift/rotate amount width (derived; do not override)

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `aluop_i`  in  8  operation code from the shared opcode defines: OR, AND, NOR, XOR, SLL, SRL, SRA, ROTR, DIV, DIVU
- `alusel_i`  in  3  result class: LOGIC, SHIFT, ARITH; any other value selects zero
- `reg1_i`  in  WIDTH  operand 1; shift amount in `[SHAMT_W-1:0]`; dividend
- `reg2_i`  in  WIDTH  operand 2; value shifted; divisor
- `wd_i`  in  REG_ADDR_W  destination register address
- `wreg_i`  in  1  destination write enable
- `flush_i`  in  1  pipeline flush; aborts a divide in progress
- `wd_o`  out  REG_ADDR_W  destination address, equal to `wd_i`
- `wreg_o`  out  1  write enable; forced to 0 while `stallreq_o`=1
- `wdata_o`  out  WIDTH  result; for DIV/DIVU this is the quotient
- `remdata_o`  out  WIDTH  remainder; valid together with the quotient, 0 otherwise
- `stallreq_o`  out  1  request to freeze PC, IF/ID and ID/EX

## Operation
- **Single-cycle ops** (combinational from the inputs):
  - OR/AND/NOR/XOR: bitwise.
  - SLL, SRL: logical shift of `reg2_i` by `reg1_i[SHAMT_W-1:0]`.
  - SRA: arithmetic shift, sign-filled from `reg2_i[WIDTH-1]`.
  - ROTR: rotate right, so that amount 0 returns `reg2_i`.
- **Divider FSM** states: IDLE, BUSY, DONE. The reset state is IDLE.
  - IDLE: with aluop DIV/DIVU and alusel ARITH:
    - Divisor ≠ 0: latch |dividend| and |divisor| (signed op) or the raw values (DIVU), plus both operand signs. Clear the bit counter and go to BUSY.
    - Divisor = 0: go directly to DONE.
  - BUSY: one restoring-division step per cycle, MSB first. The counter runs 0..WIDTH-1. When the counter equals WIDTH-1, go to DONE.
  - DONE: present the result for one cycle, then return to IDLE.
  - Sign fix for signed DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- `stallreq_o` = (IDLE ∧ divide op ∧ divisor≠0) ∨ (IDLE ∧ divide op ∧ divisor=0) ∨ BUSY. It is 0 in DONE.
- Upstream holds `aluop_i`, `reg*_i`, `wd_i` and `wreg_i` stable while `stallreq_o`=1.
- Divide by zero: quotient all-ones, remainder = dividend, for both DIV and DIVU.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value, remainder = 0. This follows naturally from the magnitude algorithm.
- `flush_i`=1 in any state: next state IDLE; counter and latched operands are don't-care. The flush wins over a DONE→IDLE or BUSY→DONE transition in the same cycle.
- Reset asserted mid-divide: FSM goes to IDLE immediately and asynchronously; no result is produced.
- Outputs while `rst`=0: `wd_o`, `wreg_o`, `wdata_o`, `remdata_o` and `stallreq_o` are all 0.

## Timing
- Logic, shift and rotate ops: 0-cycle latency, purely combinational, no stall.
- DIV/DIVU with divisor ≠ 0 (op first present at cycle 0):
  - Cycle 0: IDLE, stall.
  - Cycles 1..WIDTH: BUSY, stall.
  - Cycle WIDTH+1: DONE; results valid with `wreg_o`=`wreg_i`, no stall. The pipeline advances on the following edge.
  - Total: WIDTH+2 cycles in the stage (34 at WIDTH=32).
- Divide by zero: cycle 0 stall, cycle 1 DONE; 2 cycles total.
- Back-to-back divides: the second divide is seen in IDLE on the cycle after DONE and starts a new sequence with no gap.
- All state registers update on the rising edge of `clk` and clear asynchronously on `rst` falling.

## Configuration
- `EX_DIV_EN` defined: divider FSM, operand registers and `remdata_o` logic are built as described.
- `EX_DIV_EN` undefined:
  - No FSM or registers are built.
  - DIV/DIVU produce `wdata_o`=0 and `remdata_o`=0.
  - `stallreq_o` is tied to 0 and `wreg_o`=`wreg_i`.
  - `clk` is unused.

## Test plan
All scenarios at WIDTH=32.
- ROTR with `reg2_i`=0x8000_0001, amount 1 -> `wdata_o`=0xC000_0000 in the same cycle, `stallreq_o`=0. Amount 0 -> 0x8000_0001.
- SRA with `reg2_i`=0xF000_0000, amount 4 -> 0xFF00_0000. SRL with the same inputs -> 0x0F00_0000.
- DIV −7 ÷ 2 -> `stallreq_o` high for exactly 33 cycles. Then quotient 0xFFFF_FFFD (−3) and remainder 0xFFFF_FFFF (−1) in cycle 33, with `wreg_o`=1 only in that cycle.
- DIVU 0x8000_0000 ÷ 0 -> 1 stall cycle, then quotient 0xFFFF_FFFF, remainder 0x8000_0000. DIV 0x8000_0000 ÷ −1 -> quotient 0x8000_0000, remainder 0.
- DIVU 100 ÷ 7 with `flush_i` pulsed at cycle 10 -> `stallreq_o` drops at cycle 11, no DONE cycle occurs. A following OR 0x0F | 0xF0 -> 0xFF with no stall.
- `rst` driven low at cycle 5 of a divide -> all outputs 0 immediately. After release, DIVU 100 ÷ 7 completes normally with quotient 14, remainder 2.

Source files
------------

// File: rtl/ex_unit.sv
// ex_unit: execute stage of the scalar integer pipeline.
// Single-cycle logic/shift/rotate results, plus an iterative restoring
// divider (signed and unsigned) that stalls the front of the pipeline until
// the quotient and remainder are ready. The divider, its FSM, its operand
// registers and the remainder path are only built when the EX_DIV_EN macro is
// defined; otherwise DIV/DIVU return zero and the stage never stalls.
module ex_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [WIDTH-1:0]      reg1_i,
  input  logic [WIDTH-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic [WIDTH-1:0]      remdata_o,
  output logic                  stallreq_o
);

  // Shared opcode and result-class encodings
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ROTR = 8'h06;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] rot_left;
  logic [WIDTH-1:0]   or_res, and_res, nor_res, xor_res;
  logic [WIDTH-1:0]   sll_res, srl_res, sra_res, rotr_res;
  logic               is_div;

  assign shamt = reg1_i[SHAMT_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign or_res[gi]  = reg1_i[gi] | reg2_i[gi];
      assign and_res[gi] = reg1_i[gi] & reg2_i[gi];
      assign nor_res[gi] = ~(reg1_i[gi] | reg2_i[gi]);
      assign xor_res[gi] = reg1_i[gi] ^ reg2_i[gi];
    end
  endgenerate

  assign sll_res = reg2_i << shamt;
  assign srl_res = reg2_i >> shamt;
  assign sra_res = $signed(reg2_i) >>> shamt;

  // Left amount is (WIDTH - shamt) mod WIDTH, so amount 0 ORs reg2_i with
  // itself and returns it unchanged.
  assign rot_left = -shamt;
  assign rotr_res = srl_res | (reg2_i << rot_left);

  assign is_div = (alusel_i == SEL_ARITH) &&
                  ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_valid;
  logic             div_stall;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // quo_q starts as the dividend magnitude; each step shifts one dividend bit
  // out of the top and one quotient bit in at the bottom.
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic               divisor_zero;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;

  assign divisor_zero = (reg2_i == '0);
  assign a_neg = (aluop_i == OP_DIV) && reg1_i[WIDTH-1];
  assign b_neg = (aluop_i == OP_DIV) && reg2_i[WIDTH-1];
  assign a_mag = a_neg ? -reg1_i : reg1_i;
  assign b_mag = b_neg ? -reg2_i : reg2_i;

  // Partial remainder can reach 2*divisor-1, hence the extra bit; the top
  // bit of diff is the borrow that says the trial subtraction failed.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr_q};

  // Next-state and datapath update for the divider FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          if (divisor_zero) begin
            dz_d    = 1'b1;
            quo_d   = '1;
            rem_d   = reg1_i;
            state_d = S_DONE;
          end else begin
            dz_d      = 1'b0;
            quo_d     = a_mag;
            rem_d     = '0;
            dvsr_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A flush abandons whatever the divider was doing, including a result
    // that was about to be presented.
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  // Divider state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  // Divide-by-zero results bypass the sign fix-up
  assign div_quo   = dz_q ? quo_q : (neg_quo_q ? -quo_q : quo_q);
  assign div_rem   = dz_q ? rem_q : (neg_rem_q ? -rem_q : rem_q);
  assign div_valid = (state_q == S_DONE);
  assign div_stall = ((state_q == S_IDLE) && is_div) || (state_q == S_BUSY);
`else
  logic unused_clk;

  assign unused_clk = clk;
  assign div_quo    = '0;
  assign div_rem    = '0;
  assign div_valid  = 1'b0;
  assign div_stall  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Result selection
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rem_result;

  // Pick the result by class then opcode; unmatched combinations give zero
  always_comb begin
    result     = '0;
    rem_result = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   result = or_res;
          OP_AND:  result = and_res;
          OP_NOR:  result = nor_res;
          OP_XOR:  result = xor_res;
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result = sll_res;
          OP_SRL:  result = srl_res;
          OP_SRA:  result = sra_res;
          OP_ROTR: result = rotr_res;
          default: result = '0;
        endcase
      end
      SEL_ARITH: begin
        if (is_div && div_valid) begin
          result     = div_quo;
          rem_result = div_rem;
        end
      end
      default: begin
        result = '0;
      end
    endcase
  end

  // All outputs are held at zero while reset is asserted
  assign wd_o       = rst ? wd_i : '0;
  assign wreg_o     = rst & wreg_i & ~div_stall;
  assign wdata_o    = rst ? result : '0;
  assign remdata_o  = rst ? rem_result : '0;
  assign stallreq_o = rst & div_stall;

endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: randomized self-checking bench for ex_unit at WIDTH=32.
// Expected outputs come from a cycle-counting behavioural model; expected
// divider behaviour follows whether EX_DIV_EN is defined for the build.
module tb_ex_unit;
  localparam int W  = 32;
  localparam int RW = 5;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ROTR = 8'h06;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    aluop;
  logic [2:0]    alusel;
  logic [W-1:0]  reg1, reg2;
  logic [RW-1:0] wd;
  logic          wreg, flush;
  logic [RW-1:0] wd_o;
  logic          wreg_o;
  logic [W-1:0]  wdata_o, remdata_o;
  logic          stallreq_o;

  int n_cmp = 0;
  int n_bad = 0;
  int model_k = 0;   // cycles the current input op has been presented

  always #5 clk = ~clk;

  ex_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .remdata_o(remdata_o), .stallreq_o(stallreq_o)
  );

  // ---------------- behavioural model ----------------
  function automatic bit in_is_div();
    return (alusel == SEL_ARITH) && (aluop == OP_DIV || aluop == OP_DIVU);
  endfunction

  function automatic int stall_cycles(input logic [W-1:0] b);
    return (b == '0) ? 1 : W + 1;
  endfunction

  function automatic logic [W-1:0] ref_shift(input logic [7:0] op,
                                             input logic [W-1:0] amt_src,
                                             input logic [W-1:0] x);
    logic [W-1:0] res;
    int amt;
    amt = int'(amt_src % W);
    res = '0;
    for (int i = 0; i < W; i++) begin
      case (op)
        OP_SLL:  res[i] = (i >= amt) ? x[i-amt] : 1'b0;
        OP_SRL:  res[i] = (i + amt < W) ? x[i+amt] : 1'b0;
        OP_SRA:  res[i] = (i + amt < W) ? x[i+amt] : x[W-1];
        OP_ROTR: res[i] = x[(i + amt) % W];
        default: res[i] = 1'b0;
      endcase
    end
    return res;
  endfunction

  task automatic div_ref(input logic [7:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (op == OP_DIVU) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endtask

  task automatic expect_out(output logic [RW-1:0] e_wd, output logic e_wreg,
                            output logic [W-1:0] e_data, output logic [W-1:0] e_rem,
                            output logic e_stall);
    e_wd = '0; e_wreg = 1'b0; e_data = '0; e_rem = '0; e_stall = 1'b0;
    if (rst) begin
      e_wd = wd;
      if (DIV_EN && in_is_div() && model_k < stall_cycles(reg2)) e_stall = 1'b1;
      e_wreg = wreg && !e_stall;
      case (alusel)
        SEL_LOGIC: begin
          case (aluop)
            OP_OR:   e_data = reg1 | reg2;
            OP_AND:  e_data = reg1 & reg2;
            OP_NOR:  e_data = ~(reg1 | reg2);
            OP_XOR:  e_data = reg1 ^ reg2;
            default: e_data = '0;
          endcase
        end
        SEL_SHIFT: e_data = ref_shift(aluop, reg1, reg2);
        SEL_ARITH: begin
          if (DIV_EN && in_is_div() && model_k == stall_cycles(reg2))
            div_ref(aluop, reg1, reg2, e_data, e_rem);
        end
        default: e_data = '0;
      endcase
    end
  endtask

  // Advance the model: count cycles of a divide until its result cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) model_k <= 0;
    else if (!DIV_EN || flush || !in_is_div()) model_k <= 0;
    else if (model_k >= stall_cycles(reg2)) model_k <= 0;
    else model_k <= model_k + 1;
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    logic [RW-1:0] e_wd;
    logic          e_wreg, e_stall;
    logic [W-1:0]  e_data, e_rem;
    expect_out(e_wd, e_wreg, e_data, e_rem, e_stall);
    n_cmp++;
    if (wd_o !== e_wd || wreg_o !== e_wreg || wdata_o !== e_data ||
        remdata_o !== e_rem || stallreq_o !== e_stall) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got wd=%h wreg=%b data=%h rem=%h stall=%b; want wd=%h wreg=%b data=%h rem=%h stall=%b",
               $time, wd_o, wreg_o, wdata_o, remdata_o, stallreq_o,
               e_wd, e_wreg, e_data, e_rem, e_stall);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Present one op and hold it for as long as the stage needs it
  task automatic run_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] d, input logic we, input int flush_at,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output int stalls, output int wrs);
    int cycles;
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = we; flush = 1'b0;
    $display("op=%h sel=%b a=%h b=%h wd=%0d wreg=%b flush_at=%0d", op, sel, a, b, d, we, flush_at);
    cycles = (DIV_EN && sel == SEL_ARITH && (op == OP_DIV || op == OP_DIVU)) ?
             ((b == '0) ? 2 : W + 2) : 1;
    stalls = 0; wrs = 0; q = '0; r = '0;
    for (int c = 0; c < cycles; c++) begin
      if (c == flush_at) flush = 1'b1;
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (wreg_o) wrs++;
      q = wdata_o;
      r = remdata_o;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (c == flush_at) break;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 40));
      5: return -W'($urandom_range(1, 40));
      default: return W'($urandom);
    endcase
  endfunction

  logic [7:0] ops [10];
  logic [W-1:0] q, r;
  int stalls, wrs;

  initial begin
    ops = '{OP_OR, OP_AND, OP_NOR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_ROTR, OP_DIV, OP_DIVU};
    rst = 1'b0; flush = 1'b0;
    aluop = OP_OR; alusel = SEL_LOGIC; reg1 = 32'h0F; reg2 = 32'hF0; wd = 5'd5; wreg = 1'b1;

    // Reset state: outputs forced to zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wd", W'(wd_o), 32'h0);
    check("reset_wdata", wdata_o, 32'h0);
    check("reset_wreg", W'(wreg_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single-cycle shift/rotate pins
    run_op(OP_ROTR, SEL_SHIFT, 32'd1, 32'h8000_0001, 5'd1, 1'b1, -1, q, r, stalls, wrs);
    check("rotr1", q, 32'hC000_0000);
    check("rotr1_stall", W'(stalls), 32'd0);
    run_op(OP_ROTR, SEL_SHIFT, 32'd0, 32'h8000_0001, 5'd1, 1'b1, -1, q, r, stalls, wrs);
    check("rotr0", q, 32'h8000_0001);
    run_op(OP_SRA, SEL_SHIFT, 32'd4, 32'hF000_0000, 5'd2, 1'b1, -1, q, r, stalls, wrs);
    check("sra4", q, 32'hFF00_0000);
    run_op(OP_SRL, SEL_SHIFT, 32'd4, 32'hF000_0000, 5'd2, 1'b1, -1, q, r, stalls, wrs);
    check("srl4", q, 32'h0F00_0000);

    // Signed divide -7 / 2
    run_op(OP_DIV, SEL_ARITH, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, -1, q, r, stalls, wrs);
    check("div_m7_2_q", q, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    check("div_m7_2_r", r, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    check("div_m7_2_stalls", W'(stalls), DIV_EN ? 32'd33 : 32'd0);
    check("div_m7_2_wreg_cycles", W'(wrs), 32'd1);

    // Divide by zero and signed overflow
    run_op(OP_DIVU, SEL_ARITH, 32'h8000_0000, 32'd0, 5'd4, 1'b1, -1, q, r, stalls, wrs);
    check("divu_by0_q", q, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    check("divu_by0_r", r, DIV_EN ? 32'h8000_0000 : 32'h0);
    check("divu_by0_stalls", W'(stalls), DIV_EN ? 32'd1 : 32'd0);
    run_op(OP_DIV, SEL_ARITH, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1, -1, q, r, stalls, wrs);
    check("div_ovf_q", q, DIV_EN ? 32'h8000_0000 : 32'h0);
    check("div_ovf_r", r, 32'h0);

    // Flush at cycle 10, followed by a logic op
    run_op(OP_DIVU, SEL_ARITH, 32'd100, 32'd7, 5'd6, 1'b1, 10, q, r, stalls, wrs);
    check("flush_stalls", W'(stalls), DIV_EN ? 32'd11 : 32'd0);
    check("flush_no_write", W'(wrs), DIV_EN ? 32'd0 : 32'd1);
    run_op(OP_OR, SEL_LOGIC, 32'h0F, 32'hF0, 5'd7, 1'b1, -1, q, r, stalls, wrs);
    check("or_after_flush", q, 32'hFF);
    check("or_after_flush_stall", W'(stalls), 32'd0);

    // Reset in the middle of a divide
    aluop = OP_DIVU; alusel = SEL_ARITH; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd9; wreg = 1'b1;
    $display("op=%h sel=%b a=%h b=%h wd=%0d wreg=%b reset_at=5", aluop, alusel, reg1, reg2, wd, wreg);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("midrst_wd", W'(wd_o), 32'h0);
    check("midrst_stall", W'(stallreq_o), 32'h0);
    check("midrst_wreg", W'(wreg_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(OP_DIVU, SEL_ARITH, 32'd100, 32'd7, 5'd9, 1'b1, -1, q, r, stalls, wrs);
    check("post_rst_q", q, DIV_EN ? 32'd14 : 32'd0);
    check("post_rst_r", r, DIV_EN ? 32'd2 : 32'd0);

    // Back-to-back divides
    run_op(OP_DIV, SEL_ARITH, 32'd50, 32'hFFFF_FFFB, 5'd1, 1'b1, -1, q, r, stalls, wrs);
    check("b2b_1_q", q, DIV_EN ? 32'hFFFF_FFF6 : 32'h0);
    run_op(OP_DIVU, SEL_ARITH, 32'hFFFF_FFFF, 32'd16, 5'd1, 1'b1, -1, q, r, stalls, wrs);
    check("b2b_2_q", q, DIV_EN ? 32'h0FFF_FFFF : 32'h0);
    check("b2b_2_r", r, DIV_EN ? 32'hF : 32'h0);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 150; n++) begin
      int idx;
      int fa;
      logic [7:0] op;
      logic [2:0] sel;
      logic [W-1:0] a, b;
      idx = $urandom_range(0, 9);
      op  = ops[idx];
      sel = (idx < 4) ? SEL_LOGIC : (idx < 8) ? SEL_SHIFT : SEL_ARITH;
      if ($urandom_range(0, 9) == 0) sel = 3'($urandom);
      if ($urandom_range(0, 19) == 0) op = 8'($urandom);
      a = pick();
      b = pick();
      if (idx >= 8 && $urandom_range(0, 4) == 0) b = '0;
      fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W + 1)) : -1;
      run_op(op, sel, a, b, RW'($urandom), 1'($urandom), fa, q, r, stalls, wrs);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
